ttc_chanb_fill_queue: RTL

Parametrised TTC Channel B broadcast decoder with a fill-type queue. It sits between the TTC decoder (Brcst/BrcstStr) and the trigger logic. Fill types arrive as broadcasts ahead of their fills; the block buffers them in a FIFO and hands one to each trigger in order. It also produces counter and timestamp resets, gates asynchronous pulse storage, and keeps saturating error counters.

---
 rtl/ttc_chanb_fill_queue.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ttc_chanb_fill_queue.sv
// ttc_chanb_fill_queue
// Decodes TTC Channel B broadcast commands (Brcst[7:2] qualified by BrcstStr)
// and keeps a FIFO of fill types. Fill types arrive as broadcasts before
// their fills. Each trigger pulse takes the oldest queued type, or
// DEFAULT_FILL when the queue is empty. The block also produces the
// counter/timestamp reset pulses and the asynchronous pulse-storage enable,
// and it keeps saturating error counters.
//
// Ports
//   clk, reset_n          : clock, asynchronous active-low reset
//   chan_b_info[5:0]      : broadcast payload Brcst[7:2]
//   chan_b_valid          : payload qualifier (one cycle)
//   evt_count_reset       : event-count reset strobe from the TTC decoder
//   ttc_loopback          : synchronous clear, same effect as reset
//   trig_pulse            : one-cycle trigger, consumes one queued fill type
//   thres_unknown_ttc     : threshold for the unknown-command error flag
//   fill_type/_valid      : fill type of the latest trigger, plus a one-cycle strobe
//   accept_pulse_triggers : asynchronous pulse storage enabled
//   reset_trig_num        : evt_count_reset delayed by one cycle
//   reset_trig_timestamp  : one-cycle counter-reset pulse
//   fifo_count            : number of queued fill types
//   unknown_cmd_count, fill_ovf_count, fill_udf_count : saturating counters
//   error_unknown_ttc     : unknown_cmd_count > thres_unknown_ttc
//   error_fill_queue      : sticky flag, set on queue overflow or underflow
module ttc_chanb_fill_queue #(
  parameter int          FIFO_DEPTH   = 8,
  parameter int          CNT_WIDTH    = 32,
  parameter logic [2:0]  DEFAULT_FILL = 3'b001
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [5:0]                    chan_b_info,
  input  logic                          chan_b_valid,
  input  logic                          evt_count_reset,
  input  logic                          ttc_loopback,
  input  logic                          trig_pulse,
  input  logic [CNT_WIDTH-1:0]          thres_unknown_ttc,
  output logic [2:0]                    fill_type,
  output logic                          fill_type_valid,
  output logic                          accept_pulse_triggers,
  output logic                          reset_trig_num,
  output logic                          reset_trig_timestamp,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_WIDTH-1:0]          unknown_cmd_count,
  output logic [CNT_WIDTH-1:0]          fill_ovf_count,
  output logic [CNT_WIDTH-1:0]          fill_udf_count,
  output logic                          error_unknown_ttc,
  output logic                          error_fill_queue
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ---------------------------------------------------------------------
  // Command decode, in priority order
  // ---------------------------------------------------------------------
  logic       cmd_ctr_rst;
  logic       cmd_push;
  logic       cmd_accept;
  logic       cmd_unknown;
  logic [2:0] push_val;

  // Bits 0 and 2 of the payload carry no meaning for this block.
  logic unused_info_bits;
  assign unused_info_bits = chan_b_info[2] ^ chan_b_info[0];

  always_comb begin
    cmd_ctr_rst = 1'b0;
    cmd_push    = 1'b0;
    cmd_accept  = 1'b0;
    cmd_unknown = 1'b0;
    // A zero type code marks an asynchronous fill (3'b111).
    push_val    = (chan_b_info[4:3] == 2'b00) ? 3'b111 : {1'b0, chan_b_info[4:3]};
    if (chan_b_valid) begin
      if (chan_b_info[5:3] == 3'b001 && chan_b_info[1])
        cmd_ctr_rst = 1'b1;
      else if (!chan_b_info[1] && chan_b_info[5])
        cmd_push = 1'b1;
      else if (chan_b_info[1] && chan_b_info[5:4] == 2'b10)
        cmd_accept = 1'b1;
      else if (!evt_count_reset)
        cmd_unknown = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Queue control
  // ---------------------------------------------------------------------
  logic [2:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             q_full, q_empty;
  logic             pop_ok, pop_udf, push_ok, push_ovf;

  assign q_full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign q_empty = (count_reg == '0);
  assign pop_ok  = trig_pulse && !q_empty;
  assign pop_udf = trig_pulse && q_empty;
  // A pop in the same cycle frees the slot, so a push into a full queue
  // succeeds.
  assign push_ok  = cmd_push && (!q_full || pop_ok);
  assign push_ovf = cmd_push && q_full && !pop_ok;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (cmd_ctr_rst) begin
      // A flush and a push are separate commands, so they never meet in one
      // cycle. A same-cycle pop was already served from the old head.
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(push_ok);
      rd_ptr_next = rd_ptr_reg + PTR_W'(pop_ok);
      count_next  = count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Storage has no reset, so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok && !ttc_loopback)
      mem[wr_ptr_reg] <= push_val;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg            <= '0;
      rd_ptr_reg            <= '0;
      count_reg             <= '0;
      fill_type             <= DEFAULT_FILL;
      fill_type_valid       <= 1'b0;
      accept_pulse_triggers <= 1'b0;
      reset_trig_num        <= 1'b0;
      reset_trig_timestamp  <= 1'b0;
      error_fill_queue      <= 1'b0;
    end else if (ttc_loopback) begin
      wr_ptr_reg            <= '0;
      rd_ptr_reg            <= '0;
      count_reg             <= '0;
      fill_type             <= DEFAULT_FILL;
      fill_type_valid       <= 1'b0;
      accept_pulse_triggers <= 1'b0;
      reset_trig_num        <= 1'b0;
      reset_trig_timestamp  <= 1'b0;
      error_fill_queue      <= 1'b0;
    end else begin
      wr_ptr_reg           <= wr_ptr_next;
      rd_ptr_reg           <= rd_ptr_next;
      count_reg            <= count_next;
      fill_type_valid      <= trig_pulse;
      reset_trig_num       <= evt_count_reset;
      reset_trig_timestamp <= cmd_ctr_rst;
      if (pop_ok)
        fill_type <= mem[rd_ptr_reg];
      else if (pop_udf)
        fill_type <= DEFAULT_FILL;
      if (cmd_accept)
        accept_pulse_triggers <= ~chan_b_info[3];
      if (push_ovf || pop_udf)
        error_fill_queue <= 1'b1;
    end
  end

  assign fifo_count = count_reg;

  // ---------------------------------------------------------------------
  // Saturating status counters: 0 unknown, 1 overflow, 2 underflow
  // ---------------------------------------------------------------------
  logic [2:0]           cnt_inc;
  logic [CNT_WIDTH-1:0] cnt_reg [3];

  assign cnt_inc = {pop_udf, push_ovf, cmd_unknown};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          cnt_reg[gi] <= '0;
        else if (ttc_loopback)
          cnt_reg[gi] <= '0;
        else if (cnt_inc[gi] && cnt_reg[gi] != {CNT_WIDTH{1'b1}})
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
      end
    end
  endgenerate

  assign unknown_cmd_count = cnt_reg[0];
  assign fill_ovf_count    = cnt_reg[1];
  assign fill_udf_count    = cnt_reg[2];
  assign error_unknown_ttc = (cnt_reg[0] > thres_unknown_ttc);

endmodule
